// File: rtl/rd_req_queue_if.sv
// Bundle of the read-request queue's handshake signals: two handler-side request ports,
// the master-side req/ack head, and the occupancy/overflow status outputs.
interface rd_req_queue_if #(
   parameter int unsigned AWIDTH = 32,
   parameter int unsigned DEPTH  = 4
);
   logic                         in0_wren;
   logic [AWIDTH-1:0]            in0_addr;
   logic                         in0_full;
   logic                         in1_wren;
   logic [AWIDTH-1:0]            in1_addr;
   logic                         in1_full;
   logic                         m_req;
   logic [AWIDTH-1:0]            m_addr;
   logic                         m_src;
   logic                         m_ack;
   logic [$clog2(DEPTH+1)-1:0]   level;
   logic [1:0]                   ovf;

   modport slave (
      input  in0_wren, in0_addr, in1_wren, in1_addr, m_ack,
      output in0_full, in1_full, m_req, m_addr, m_src, level, ovf
   );

   modport master (
      output in0_wren, in0_addr, in1_wren, in1_addr, m_ack,
      input  in0_full, in1_full, m_req, m_addr, m_src, level, ovf
   );
endinterface

// File: rtl/rd_req_queue.sv
// Per-master read-request queue: two hold registers, round-robin arbiter, DEPTH-entry FIFO
// tagged with source port. Define RD_REQ_QUEUE_OVF_EN to enable sticky per-port overflow flags.
module rd_req_queue #(
   parameter int unsigned AWIDTH = 32,
   parameter int unsigned DEPTH  = 4
) (
   input logic          aclk,
   input logic          aresetn,
   rd_req_queue_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [1:0]              hold_valid_q, hold_valid_d;
   logic [1:0][AWIDTH-1:0]  hold_addr_q, hold_addr_d;
   logic                    rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [AWIDTH:0]         mem_q [DEPTH];
   logic [AWIDTH:0]         mem_d [DEPTH];

   logic [1:0]              wren;
   logic [1:0][AWIDTH-1:0]  addr_in;
   logic                    grant, grant_src, pop;

   assign wren    = {bus.in1_wren, bus.in0_wren};
   assign addr_in = {bus.in1_addr, bus.in0_addr};

   always_comb begin
      grant     = 1'b0;
      grant_src = 1'b0;
      // A full FIFO blocks the grant even when the head is popped this cycle.
      if (count_q != CW'(DEPTH)) begin
         if (hold_valid_q[0] && hold_valid_q[1]) begin
            grant     = 1'b1;
            grant_src = rr_ptr_q;
         end else if (hold_valid_q[0]) begin
            grant     = 1'b1;
            grant_src = 1'b0;
         end else if (hold_valid_q[1]) begin
            grant     = 1'b1;
            grant_src = 1'b1;
         end
      end
      pop = (count_q != '0) && bus.m_ack;

      rr_ptr_d = grant ? ~grant_src : rr_ptr_q;
      for (int k = 0; k < 2; k++) begin
         hold_addr_d[k] = hold_addr_q[k];
         if (hold_valid_q[k]) begin
            hold_valid_d[k] = !(grant && (grant_src == k[0]));
         end else begin
            hold_valid_d[k] = wren[k];
            if (wren[k]) hold_addr_d[k] = addr_in[k];
         end
      end

      mem_d = mem_q;
      if (grant) mem_d[wr_ptr_q] = {grant_src, hold_addr_q[grant_src]};
      wr_ptr_d = grant ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(grant) - CW'(pop);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         hold_valid_q <= '0;
         rr_ptr_q     <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge aclk) begin
      hold_addr_q <= hold_addr_d;
      mem_q       <= mem_d;
   end

   assign bus.in0_full = hold_valid_q[0];
   assign bus.in1_full = hold_valid_q[1];
   assign bus.m_req    = (count_q != '0);
   // Gated so the head reads as zero out of reset, before storage is ever written.
   assign bus.m_addr   = bus.m_req ? mem_q[rd_ptr_q][AWIDTH-1:0] : '0;
   assign bus.m_src    = bus.m_req ? mem_q[rd_ptr_q][AWIDTH] : 1'b0;
   assign bus.level    = count_q;

`ifdef RD_REQ_QUEUE_OVF_EN
   logic [1:0] ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q | (wren & hold_valid_q);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) ovf_q <= '0;
      else          ovf_q <= ovf_d;
   end

   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 2'b00;
`endif
endmodule
